vdc_vtiming_meter: RTL and testbench
====================================

Name: vdc_vtiming_meter

Overview:
- Receiving end of the VDC vertical sync/blank interface: watches hSyncStart, vsync and vblank and recovers the vertical frame geometry.
- Recovered values: lines per frame, vsync width, vblank width, vblank-to-vsync offset, and interlace/field phase (half-line vsync).
- Feeds the video output/scaler path and the VDC self-test logic; reports lock once timing is stable.

Parameters:
- LINE_BITS, 10, width of all line counters/results.
- HCNT_BITS, 12, width of the horizontal period counter (enabled cycles).
- LOCK_FRAMES, 2, consecutive matching frames required to assert locked (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  clock enable; all state frozen when low
- hSyncStart  in  1  one-enable-cycle pulse at each line start
- vsync  in  1  vertical sync level
- vblank  in  1  vertical blank level
- frameStart  out  1  one-enable-cycle pulse on the first hSyncStart at or after a vsync rise
- lines  out  LINE_BITS  lines in the last complete frame
- vsLines  out  LINE_BITS  hSyncStarts counted while vsync high, last frame
- vbLines  out  LINE_BITS  hSyncStarts counted while vblank high, last frame
- vbToVs  out  LINE_BITS  hSyncStarts from vblank rise to vsync rise, last frame
- field  out  1  1 = last vsync rose mid-line (second field)
- interlaced  out  1  field alternated over the last two frames
- locked  out  1  geometry stable for LOCK_FRAMES frames
- changed  out  1  see Optional Feature

Behaviour:
- Reset: all outputs 0; FSM=SEARCH; all counters 0. Reset mid-frame discards partial measurements.
- hcount: +1 per enabled cycle, saturating; cleared on hSyncStart, which first latches hperiod<=hcount.
- Vsync/vblank rise detection uses registered previous levels, updated only on enable.
- Vsync rise half flag: half=1 iff hperiod/4 <= hcount < 3*hperiod/4, using shifts with HCNT_BITS+1 arithmetic. A rise in the same cycle as hSyncStart uses hcount=0, so half=0.
- Frame boundary is the first hSyncStart at or after a vsync rise, including the same cycle. At the boundary:
  - frameStart=1 for that cycle.
  - Latch lines<=lcnt+1, vsLines, vbLines, vbToVs, field<=half.
  - lcnt<=0 and per-frame counters clear.
- Otherwise every hSyncStart: lcnt+1, saturating at all-ones.
- vs/vb counters: +1 per hSyncStart while the level is high, including the boundary line.
- vbToVs counter: cleared on vblank rise; +1 per hSyncStart until vsync rise; 0 if vsync rises first.
- interlaced<=(half != previous half) at each boundary.
- FSM:
  - SEARCH -> MEASURE on the first boundary; that frame's values are not compared.
  - MEASURE: compare the new frame against the previous one. Match means vsLines, vbLines and vbToVs equal, and lines equal (progressive) or |diff|<=1 (interlaced). Match increments mcount; at mcount==LOCK_FRAMES -> LOCKED, locked=1. Mismatch clears mcount.
  - LOCKED: a mismatch -> MEASURE, locked=0, mcount=0.
  - Any state: lcnt reaching all-ones (vsync lost) -> SEARCH, locked=0, outputs hold last values.
- hperiod==0 (hsync absent): half forced 0.

Optional Feature:
- Macro VDC_VTIMING_CHANGE_EN.
- Defined: changed pulses for one enable cycle on any locked 1->0 transition, and on any boundary where the new lines/vsLines/vbLines/vbToVs differ from the previous frame.
- Undefined: changed tied to 0, no extra logic.

Test Plan:
- Progressive: hperiod 64, 262 lines, vblank rises line 240 for 20 lines, vsync rises line 244 for 3 lines. Expected: lines=262, vsLines=3, vbLines=20, vbToVs=4, field=0, interlaced=0, locked=1 on the 3rd boundary (LOCK_FRAMES=2).
- Interlace: as above, but every other frame has vsync rising at hcount 32 and 263 lines. Expected: field toggles 0/1, interlaced=1, locked=1.
- Mismatch: after lock, one frame of 270 lines. Expected: locked drops on that boundary and reasserts after 2 further matching 262-line frames; changed pulses with VDC_VTIMING_CHANGE_EN.
- Timeout: vsync held low. Expected: lcnt saturates at 1023, FSM=SEARCH, locked=0, lines unchanged.
- Edge: vsync rising in the same cycle as hSyncStart. Expected: frameStart that cycle, half=0.
- Edge: enable=0 for 100 cycles mid-frame. Expected: identical results to an uninterrupted run.
- Edge: reset asserted mid-frame. Expected: all outputs 0.

Source files
------------

// File: rtl/vdc_vtiming_meter.sv
// Recovers vertical frame geometry (lines, vsync/vblank widths, field phase) from the VDC sync stream.
// Define VDC_VTIMING_CHANGE_EN to build the `changed` pulse output; otherwise it is tied low.
module vdc_vtiming_meter #(
  parameter int LINE_BITS   = 10,
  parameter int HCNT_BITS   = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 hSyncStart,
  input  logic                 vsync,
  input  logic                 vblank,
  output logic                 frameStart,
  output logic [LINE_BITS-1:0] lines,
  output logic [LINE_BITS-1:0] vsLines,
  output logic [LINE_BITS-1:0] vbLines,
  output logic [LINE_BITS-1:0] vbToVs,
  output logic                 field,
  output logic                 interlaced,
  output logic                 locked,
  output logic                 changed
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [LINE_BITS-1:0] L_ONE  = 1;
  localparam logic [LINE_BITS-1:0] L_MAX  = '1;
  localparam logic [LINE_BITS:0]   LX_ONE = 1;
  localparam logic [HCNT_BITS-1:0] H_ONE  = 1;
  localparam logic [3:0]           LOCK_N = 4'(LOCK_FRAMES);

  function automatic logic [LINE_BITS-1:0] sat_inc(input logic [LINE_BITS-1:0] v);
    return (v == L_MAX) ? v : v + L_ONE;
  endfunction

  state_t               state;
  logic [HCNT_BITS-1:0] hcount, hperiod, hc_eff;
  logic [HCNT_BITS:0]   hp_ext, hc_ext, q1, q3;
  logic                 vs_prev, vb_prev, vs_rise, vb_rise;
  logic                 pend, pend_half, half_now, half_eff;
  logic                 vbv_run, skip_cmp, boundary, lost;
  logic [LINE_BITS-1:0] lcnt, vs_cnt, vb_cnt, vbv_cnt, new_lines, new_vbv;
  logic [LINE_BITS:0]   nl_ext, ol_ext;
  logic                 new_il, lines_ok, match;
  logic [3:0]           mcount, mc_inc;

  always_comb begin
    vs_rise  = vsync & ~vs_prev;
    vb_rise  = vblank & ~vb_prev;
    // A rise coinciding with hSyncStart is at the very start of the line.
    hc_eff   = hSyncStart ? '0 : hcount;
    hp_ext   = {1'b0, hperiod};
    hc_ext   = {1'b0, hc_eff};
    q1       = hp_ext >> 2;
    q3       = (hp_ext >> 1) + (hp_ext >> 2);
    half_now = (hperiod != '0) && (hc_ext >= q1) && (hc_ext < q3);
    half_eff = vs_rise ? half_now : pend_half;
    boundary = enable & ~reset & hSyncStart & (pend | vs_rise);
    new_lines = sat_inc(lcnt);
    lost     = hSyncStart && !boundary && (new_lines == L_MAX);
    new_vbv  = (vs_rise && !vbv_run) ? '0 : vbv_cnt;
    new_il   = half_eff != field;
    nl_ext   = {1'b0, new_lines};
    ol_ext   = {1'b0, lines};
    lines_ok = (nl_ext == ol_ext) ||
               (new_il && ((nl_ext == ol_ext + LX_ONE) || (ol_ext == nl_ext + LX_ONE)));
    match    = lines_ok && (vs_cnt == vsLines) && (vb_cnt == vbLines) && (new_vbv == vbToVs);
    mc_inc   = skip_cmp ? 4'd1 : mcount + 4'd1;
  end

  assign frameStart = boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;   hcount <= '0;   hperiod <= '0;
      vs_prev <= 1'b0;   vb_prev <= 1'b0; pend <= 1'b0; pend_half <= 1'b0;
      vbv_run <= 1'b0;   skip_cmp <= 1'b0; mcount <= '0;
      lcnt <= '0; vs_cnt <= '0; vb_cnt <= '0; vbv_cnt <= '0;
      lines <= '0; vsLines <= '0; vbLines <= '0; vbToVs <= '0;
      field <= 1'b0; interlaced <= 1'b0; locked <= 1'b0;
    end else if (enable) begin
      vs_prev <= vsync;
      vb_prev <= vblank;
      if (hSyncStart) begin
        hperiod <= hcount;
        hcount  <= '0;
      end else if (hcount != '1) begin
        hcount <= hcount + H_ONE;
      end

      if (vb_rise) begin
        vbv_cnt <= hSyncStart ? L_ONE : '0;
        vbv_run <= 1'b1;
      end else if (hSyncStart && vbv_run && !vs_rise) begin
        vbv_cnt <= sat_inc(vbv_cnt);
      end
      if (vs_rise) begin
        vbv_run <= 1'b0;
        if (!vbv_run) vbv_cnt <= '0;
      end

      if (boundary) pend <= 1'b0;
      else if (vs_rise) begin
        pend      <= 1'b1;
        pend_half <= half_now;
      end

      if (boundary) begin
        lines <= new_lines;  vsLines <= vs_cnt;  vbLines <= vb_cnt;  vbToVs <= new_vbv;
        field <= half_eff;   interlaced <= new_il;
        lcnt  <= '0;
        vs_cnt <= vsync  ? L_ONE : '0;
        vb_cnt <= vblank ? L_ONE : '0;
        case (state)
          SEARCH: begin
            state    <= MEASURE;
            mcount   <= '0;
            skip_cmp <= 1'b1;
          end
          MEASURE: begin
            // The first full frame after SEARCH has no reference; it opens the run.
            if (skip_cmp || match) begin
              skip_cmp <= 1'b0;
              mcount   <= mc_inc;
              if (mc_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              mcount <= '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              state  <= MEASURE;
              locked <= 1'b0;
              mcount <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end else if (hSyncStart) begin
        lcnt <= new_lines;
        if (vsync)  vs_cnt <= sat_inc(vs_cnt);
        if (vblank) vb_cnt <= sat_inc(vb_cnt);
        if (lost) begin
          state    <= SEARCH;
          locked   <= 1'b0;
          mcount   <= '0;
          skip_cmp <= 1'b0;
        end
      end
    end
  end

`ifdef VDC_VTIMING_CHANGE_EN
  logic differ, drop;
  assign differ = (new_lines != lines) || (vs_cnt != vsLines) ||
                  (vb_cnt != vbLines) || (new_vbv != vbToVs);
  assign drop   = locked && ((boundary && (state == LOCKED) && !match) || (enable && lost));

  always_ff @(posedge clk) begin
    if (reset)       changed <= 1'b0;
    else if (enable) changed <= (boundary && differ) || drop;
  end
`else
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_vdc_vtiming_meter.sv
// Directed bench for vdc_vtiming_meter: 8-cycle lines, progressive/interlaced fields, lock, timeout, enable gap, reset.
module tb_vdc_vtiming_meter;
  localparam int LB = 10;
`ifdef VDC_VTIMING_CHANGE_EN
  localparam int CH = 1;
`else
  localparam int CH = 0;
`endif

  logic clk = 1'b0;
  logic reset, enable, hSyncStart, vsync, vblank;
  logic frameStart, field, interlaced, locked, changed;
  logic [LB-1:0] lines, vsLines, vbLines, vbToVs;

  int checks = 0;
  int errors = 0;
  int fs_cnt, fs_t, ch_cnt;

  always #5 clk = ~clk;

  vdc_vtiming_meter #(.LINE_BITS(LB), .HCNT_BITS(12), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hSyncStart(hSyncStart),
    .vsync(vsync), .vblank(vblank), .frameStart(frameStart), .lines(lines),
    .vsLines(vsLines), .vbLines(vbLines), .vbToVs(vbToVs), .field(field),
    .interlaced(interlaced), .locked(locked), .changed(changed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic vb, input int t);
    @(negedge clk);
    enable = 1'b1; hSyncStart = hs; vsync = vs; vblank = vb;
    #1;
    if (frameStart) begin fs_cnt++; fs_t = t; end
    if (changed) ch_cnt++;
  endtask

  // One field: vblank rises at line 0 (+2 cycles if mid), vsync 4 lines later for 3 lines, vblank 20 lines.
  task automatic field_gen(input int n, input int m, input int gap_at);
    int sw;
    sw = (m != 0) ? 2 : 0;
    fs_cnt = 0; ch_cnt = 0; fs_t = -1;
    for (int t = 0; t < n * 8; t++) begin
      if (t == gap_at) begin
        for (int g = 0; g < 100; g++) begin
          @(negedge clk);
          enable = 1'b0; hSyncStart = g[0]; vsync = g[1]; vblank = g[2];
          #1;
          if (frameStart) fs_cnt++;
        end
      end
      cyc((t % 8) == 0, (t >= 32 + sw) && (t < 56 + sw), (t >= sw) && (t < 160 + sw), t);
    end
  endtask

  task automatic chk_frame(input string tag, input int ln, input int fld, input int il,
                           input int lk, input int fst, input int ch);
    chk({tag, " lines"}, 32'(lines), ln);
    chk({tag, " vsLines"}, 32'(vsLines), 3);
    chk({tag, " vbLines"}, 32'(vbLines), 20);
    chk({tag, " vbToVs"}, 32'(vbToVs), 4);
    chk({tag, " field"}, 32'(field), fld);
    chk({tag, " interlaced"}, 32'(interlaced), il);
    chk({tag, " locked"}, 32'(locked), lk);
    chk({tag, " frameStart count"}, fs_cnt, 1);
    chk({tag, " frameStart cycle"}, fs_t, fst);
    chk({tag, " changed pulses"}, ch_cnt, ch);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " lines"}, 32'(lines), 0);
    chk({tag, " vsLines"}, 32'(vsLines), 0);
    chk({tag, " vbLines"}, 32'(vbLines), 0);
    chk({tag, " vbToVs"}, 32'(vbToVs), 0);
    chk({tag, " field"}, 32'(field), 0);
    chk({tag, " interlaced"}, 32'(interlaced), 0);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " changed"}, 32'(changed), 0);
    chk({tag, " frameStart"}, 32'(frameStart), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; hSyncStart = 1'b0; vsync = 1'b0; vblank = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Progressive 262-line fields; vsync rises together with hSyncStart.
    field_gen(262, 0, -1);
    chk("p1 locked", 32'(locked), 0);
    chk("p1 frameStart count", fs_cnt, 1);
    chk("p1 frameStart cycle", fs_t, 32);
    chk("p1 field", 32'(field), 0);
    field_gen(262, 0, -1);
    chk_frame("p2", 262, 0, 0, 0, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("p3", 262, 0, 0, 1, 32, 0);

    // Interlace: odd fields have vsync rising mid-line and 263 lines.
    field_gen(263, 1, -1);
    chk_frame("i4", 263, 1, 1, 1, 40, CH);
    field_gen(262, 0, -1);
    chk_frame("i5", 262, 0, 1, 1, 32, CH);
    field_gen(263, 1, -1);
    chk_frame("i6", 263, 1, 1, 1, 40, CH);
    field_gen(262, 0, -1);
    chk_frame("i7", 262, 0, 1, 1, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("p8", 262, 0, 0, 1, 32, 0);

    // One 270-line frame breaks lock; two further matching frames restore it.
    field_gen(270, 0, -1);
    chk_frame("m9", 262, 0, 0, 1, 32, 0);
    field_gen(262, 0, -1);
    chk_frame("m10", 270, 0, 0, 0, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("m11", 262, 0, 0, 0, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("m12", 262, 0, 0, 0, 32, 0);
    field_gen(262, 0, -1);
    chk_frame("m13", 262, 0, 0, 1, 32, 0);

    // Enable held low for 100 cycles mid-frame with garbage on the inputs.
    field_gen(262, 0, 1000);
    chk_frame("g14", 262, 0, 0, 1, 32, 0);
    field_gen(262, 0, -1);
    chk_frame("g15", 262, 0, 0, 1, 32, 0);

    // Vsync lost: line counter saturates and the meter falls back to searching.
    fs_cnt = 0; ch_cnt = 0;
    for (int t = 0; t < 800 * 8; t++) cyc((t % 8) == 0, 1'b0, 1'b0, t);
    chk("timeout locked", 32'(locked), 0);
    chk("timeout lines held", 32'(lines), 262);
    chk("timeout vsLines held", 32'(vsLines), 3);
    chk("timeout frameStart count", fs_cnt, 0);
    chk("timeout changed pulses", ch_cnt, CH);
    field_gen(262, 0, -1);
    chk_frame("t16", 1023, 0, 0, 0, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("t17", 262, 0, 0, 0, 32, CH);
    field_gen(262, 0, -1);
    chk_frame("t18", 262, 0, 0, 1, 32, 0);

    // Reset in the middle of a frame.
    for (int t = 0; t < 500; t++)
      cyc((t % 8) == 0, (t >= 32) && (t < 56), t < 160, t);
    @(negedge clk);
    reset = 1'b1; hSyncStart = 1'b1; vsync = 1'b1; vblank = 1'b1;
    @(negedge clk);
    #1;
    chk_zero("midreset");
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
